// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receive and transmit sides: FSM state
//   encodings, frame constants, and the mid-bit offset helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Receiver FSM states. Encodings 5..7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;

    // Number of clocks from start-bit detection to the start-bit sample point.
    function automatic int mid_point(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
//   Bundles the serial input and the byte-side handshake of the UART receiver.
//   Signals:
//     rxIn      serial line, idle high           (master -> slave)
//     rxRead    consumer pops the held byte      (master -> slave)
//     rxData    received byte                    (slave -> master)
//     rxValid   holding register full            (slave -> master)
//     rxBusy    frame in progress                (slave -> master)
//     frameErr  one-cycle stop-bit error pulse   (slave -> master)
//     overrun   one-cycle overrun pulse          (slave -> master)
//   The receiver uses the slave modport; the line driver / consumer the master.
// -----------------------------------------------------------------------------
interface uart_receiver_if;
    logic       rxIn;
    logic       rxRead;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxBusy;
    logic       frameErr;
    logic       overrun;

    modport master (
        output rxIn, rxRead,
        input  rxData, rxValid, rxBusy, frameErr, overrun
    );

    modport slave (
        input  rxIn, rxRead,
        output rxData, rxValid, rxBusy, frameErr, overrun
    );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_timer
//   Down-counter producing a one-cycle sample strobe MID cycles after a
//   restart, then every CLKS_PER_BIT cycles. When MID is 0 the first sample is
//   taken by the FSM in the restart cycle itself, so the first strobe from
//   here lands one full bit later.
//   Ports:
//     CLK      in   clock
//     RST      in   synchronous active-high reset
//     restart  in   start bit detected this cycle
//     strobe   out  sample the line this cycle
// -----------------------------------------------------------------------------
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic strobe
);

    localparam int MID = mid_point(CLKS_PER_BIT);
    localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FIRST = (MID == 0) ? LAST : CW'(MID - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Counter reaches zero on a sample cycle, then reloads for the next bit.
    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = FIRST;
        end else if (count_q == '0) begin
            count_d = LAST;
        end else begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign strobe = (count_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   Receive side of an 8N1 UART link (LSB first, idle-high line). Samples each
//   bit at mid-bit, reassembles bytes, and presents them through a one-entry
//   holding register with a valid/read handshake. Flags framing errors and
//   overruns with one-cycle pulses.
//   Parameters:
//     CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//   Ports:
//     CLK  in  clock, rising edge
//     RST  in  synchronous active-high reset
//     rx   uart_receiver_if.slave: rxIn, rxRead in; rxData, rxValid,
//          rxBusy, frameErr, overrun out
//   Build option:
//     RX_SYNC_EN  when defined, rxIn passes through a 2-flop synchronizer
//                 (reset to 1) and all timing shifts by two cycles.
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            CLK,
    input  logic            RST,
    uart_receiver_if.slave  rx
);

    localparam int MID = mid_point(CLKS_PER_BIT);

    logic rx_s;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], rx.rxIn};
    end

    // Reset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx.rxIn;
`endif

    uart_state_e state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        restart;
    logic        commit;
    logic        strobe;

    uart_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .CLK     (CLK),
        .RST     (RST),
        .restart (restart),
        .strobe  (strobe)
    );

    // Framing FSM: next state, shift register, error pulse.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        restart     = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_s == START_BIT) begin
                    restart   = 1'b1;
                    bit_cnt_d = '0;
                    // With MID==0 this cycle is already the start-bit sample.
                    state_d   = (MID == 0) ? DATA : START;
                end
            end
            START: begin
                if (strobe) begin
                    state_d = (rx_s == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (strobe) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (strobe) begin
                    if (rx_s == STOP_BIT) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must go high before a new start is accepted.
                if (rx_s == STOP_BIT) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register. A commit takes priority over a read; a commit onto
    // an unread byte overwrites it and reports an overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (commit) begin
            data_d    = shift_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !rx.rxRead;
        end else if (rx.rxRead && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx.rxData   = data_q;
    assign rx.rxValid  = valid_q;
    assign rx.rxBusy   = (state_q != IDLE);
    assign rx.frameErr = frame_err_q;
    assign rx.overrun  = overrun_q;

endmodule
